ram_port_arbiter: RTL

- Two-requester arbiter and sequencer for the shared 512x8 synchronous work RAM wrapper.
- Requester A is the CPU-side bus adapter. Requester B is a secondary master, such as a UART boot loader or debug monitor.
- Serialises accesses with round-robin fairness and drives the RAM's single address/data/rden/wren port.
- Returns a registered read-data and acknowledge pulse to each requester.

---
 rtl/ram_port_arbiter_if.sv | 18 +
 rtl/ram_port_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// One requester's command/response bundle toward the shared work-RAM arbiter.
interface ram_port_arbiter_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 8
) ();
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    // Requester side drives the command, arbiter side returns ack/rdata.
    modport master (output req, output wr, output addr, output wdata,
                    input ack, input rdata);
    modport slave  (input req, input wr, input addr, input wdata,
                    output ack, output rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port 512x8 work RAM.
// Each granted access takes IDLE -> ACCESS -> DONE; ack and read data are registered.
module ram_port_arbiter #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 8
) (
    input  logic                  i_clk,
    input  logic                  i_n_rst,
    ram_port_arbiter_if.slave     a_if,
    ram_port_arbiter_if.slave     b_if,
    output logic [AW-1:0]         o_mem_addr,
    output logic [DW-1:0]         o_mem_wdata,
    output logic                  o_mem_rden,
    output logic                  o_mem_wren,
    input  logic [DW-1:0]         i_mem_q,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    state_e        r_state,     w_state;
    logic          r_owner,     w_owner;     // 0 = A, 1 = B
    logic          r_wr,        w_wr;
    logic          r_last_b,    w_last_b;    // last grant went to B
    logic [AW-1:0] r_mem_addr,  w_mem_addr;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata;
    logic          r_mem_rden,  w_mem_rden;
    logic          r_mem_wren,  w_mem_wren;
    logic          r_a_ack,     w_a_ack;
    logic          r_b_ack,     w_b_ack;
    logic [DW-1:0] r_a_rdata,   w_a_rdata;
    logic [DW-1:0] r_b_rdata,   w_b_rdata;
    logic          r_busy,      w_busy;

    logic          w_elig_a;
    logic          w_elig_b;
    logic          w_grant_b;

    // Arbitration and next-state/output decode.
    always_comb begin
        w_state     = r_state;
        w_owner     = r_owner;
        w_wr        = r_wr;
        w_last_b    = r_last_b;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_rden  = 1'b0;
        w_mem_wren  = 1'b0;
        w_a_ack     = 1'b0;
        w_b_ack     = 1'b0;
        w_a_rdata   = r_a_rdata;
        w_b_rdata   = r_b_rdata;

        // A requester still holding req on its own ack cycle is not re-eligible yet.
        w_elig_a  = a_if.req & ~r_a_ack;
        w_elig_b  = b_if.req & ~r_b_ack;
        w_grant_b = w_elig_b & (~w_elig_a | ~r_last_b);

        unique case (r_state)
            StIdle: begin
                if (w_elig_a || w_elig_b) begin
                    w_owner  = w_grant_b;
                    w_last_b = w_grant_b;
                    if (w_grant_b) begin
                        w_wr        = b_if.wr;
                        w_mem_addr  = b_if.addr;
                        w_mem_wdata = b_if.wdata;
                    end else begin
                        w_wr        = a_if.wr;
                        w_mem_addr  = a_if.addr;
                        w_mem_wdata = a_if.wdata;
                    end
                    w_mem_wren = w_wr;
                    w_mem_rden = ~w_wr;
                    w_state    = StAccess;
                end
            end
            StAccess: begin
                w_state = StDone;
            end
            StDone: begin
                // mem_q is valid this cycle for the read issued in ACCESS.
                if (r_owner) begin
                    w_b_ack = 1'b1;
                    if (!r_wr) begin
                        w_b_rdata = i_mem_q;
                    end
                end else begin
                    w_a_ack = 1'b1;
                    if (!r_wr) begin
                        w_a_rdata = i_mem_q;
                    end
                end
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase

        w_busy = (w_state != StIdle);
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state     <= StIdle;
            r_owner     <= 1'b0;
            r_wr        <= 1'b0;
            r_last_b    <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rden  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_owner     <= w_owner;
            r_wr        <= w_wr;
            r_last_b    <= w_last_b;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_rden  <= w_mem_rden;
            r_mem_wren  <= w_mem_wren;
            r_a_ack     <= w_a_ack;
            r_b_ack     <= w_b_ack;
            r_a_rdata   <= w_a_rdata;
            r_b_rdata   <= w_b_rdata;
            r_busy      <= w_busy;
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_rden  = r_mem_rden;
    assign o_mem_wren  = r_mem_wren;
    assign o_busy      = r_busy;
    assign a_if.ack    = r_a_ack;
    assign a_if.rdata  = r_a_rdata;
    assign b_if.ack    = r_b_ack;
    assign b_if.rdata  = r_b_rdata;

    // Structural invariants of the RAM port and the ack pulses.
    a_one_enable : assert property (@(posedge i_clk) disable iff (!i_n_rst)
        !(r_mem_rden && r_mem_wren));
    a_one_ack : assert property (@(posedge i_clk) disable iff (!i_n_rst)
        !(r_a_ack && r_b_ack));
    a_enable_in_access : assert property (@(posedge i_clk) disable iff (!i_n_rst)
        (r_mem_rden || r_mem_wren) == (r_state == StAccess));

endmodule
